imem_fetch_ctrl: RTL and testbench

- Instruction-memory fetch controller upstream of the PC-select/fetch logic.
- Takes the current PC address and returns the instruction word.
- Talks to a variable-latency instruction memory over a req/ack handshake, and asserts stall so the PC register holds on a miss.
- Keeps a single-entry last-fetch buffer, so loops on a single instruction and held PCs are served without a memory access.

---
 rtl/imem_fetch_pkg.sv | 21 ++
 rtl/imem_fetch_ctrl_line_buffer.sv | 38 +++
 rtl/imem_fetch_ctrl.sv | 151 +++++++++++++++
 tb/tb_imem_fetch_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/imem_fetch_pkg.sv
// Shared constants and types for the instruction-memory fetch controller.
//   ST_*             FSM state encoding
//   NOP_INST_DEFAULT instruction word presented when nothing valid exists
//   WADDR_W          width of a word address (byte address bits [31:2])
//   line_t           tag/data payload of the last-fetch buffer
package imem_fetch_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0000;

  localparam int unsigned WADDR_W = 30;

  typedef struct packed {
    logic [WADDR_W-1:0] tag;
    logic [31:0]        data;
  } line_t;

endpackage

// File: rtl/imem_fetch_ctrl_line_buffer.sv
// Single-entry last-fetch buffer: tag/data register with write enable and
// a combinational hit compare.
//   clk, rst_n  clock, async active-low clear (valid and contents)
//   we          write {wr_tag, wr_data} at the next rising edge
//   rd_tag      word address to compare against the stored tag
//   hit_c       buffer valid and tag matches (combinational)
//   rd_data     stored instruction word
module fetch_line_buffer
  import imem_fetch_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               we,
  input  logic [WADDR_W-1:0] wr_tag,
  input  logic [31:0]        wr_data,
  input  logic [WADDR_W-1:0] rd_tag,
  output logic               hit_c,
  output logic [31:0]        rd_data
);

  logic  valid_q;
  line_t line_q;

  // Storage register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      line_q  <= '0;
    end else if (we) begin
      valid_q <= 1'b1;
      line_q  <= '{tag: wr_tag, data: wr_data};
    end
  end

  assign hit_c   = valid_q && (line_q.tag == rd_tag);
  assign rd_data = line_q.data;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction-memory fetch controller: serves pc_addr from a one-entry
// last-fetch buffer or from a variable-latency memory over req/ack, stalling
// the PC on a miss and faulting on misalignment or memory timeout.
//   clk, rst_n            clock, async active-low reset
//   pc_addr, pc_valid     fetch request from the PC logic
//   flush                 PC redirect; discard any in-flight result
//   inst, inst_valid      instruction word to decode (combinational)
//   stall                 hold the PC register (combinational)
//   fetch_fault           misaligned PC or memory timeout (combinational)
//   mem_req, mem_addr     registered memory request
//   mem_ack, mem_rdata    memory acceptance and data
module imem_fetch_ctrl
  import imem_fetch_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [31:0] NOP_INST       = NOP_INST_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_addr,
  input  logic        pc_valid,
  input  logic        flush,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic        stall,
  output logic        fetch_fault,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_sat;
  logic [31:0]      mem_addr_q;
  logic             mem_req_q;
  logic             issue;
  logic             buf_we;
  logic             buf_hit;
  logic [31:0]      buf_data;
  logic             aligned;
  logic             timeout;
  logic [31:0]      inst_v;
  logic             inst_valid_v, stall_v, fault_v;

  fetch_line_buffer u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (buf_we),
    .wr_tag  (mem_addr_q[31:2]),
    .wr_data (mem_rdata),
    .rd_tag  (pc_addr[31:2]),
    .hit_c   (buf_hit),
    .rd_data (buf_data)
  );

  assign aligned = (pc_addr[1:0] == 2'b00);
  assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign cnt_sat = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

  // State, request and timeout registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      // Request is live exactly while the memory owes us an ack
      mem_req_q <= (state_d != ST_IDLE);
      if (issue) mem_addr_q <= {pc_addr[31:2], 2'b00};
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    issue        = 1'b0;
    buf_we       = 1'b0;
    inst_v       = NOP_INST;
    inst_valid_v = 1'b0;
    stall_v      = 1'b0;
    fault_v      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pc_valid) begin
          if (!aligned) begin
            inst_valid_v = 1'b1;
            fault_v      = 1'b1;
          end else if (buf_hit) begin
            inst_v       = buf_data;
            inst_valid_v = 1'b1;
          end else begin
            stall_v = 1'b1;
            issue   = 1'b1;
            cnt_d   = '0;
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (mem_ack) begin
          state_d = ST_IDLE;
          if (!flush) begin
            inst_v       = mem_rdata;
            inst_valid_v = 1'b1;
            buf_we       = 1'b1;
          end
        end else if (timeout) begin
          inst_valid_v = 1'b1;
          fault_v      = 1'b1;
          state_d      = ST_IDLE;
        end else if (flush) begin
          cnt_d   = cnt_sat;
          state_d = ST_DRAIN;
        end else begin
          stall_v = 1'b1;
          cnt_d   = cnt_sat;
        end
      end
      ST_DRAIN: begin
        // Orphaned request: wait it out silently, serve only buffer hits
        if (mem_ack || timeout) state_d = ST_IDLE;
        else                    cnt_d   = cnt_sat;
        if (pc_valid) begin
          if (aligned && buf_hit) begin
            inst_v       = buf_data;
            inst_valid_v = 1'b1;
          end else begin
            stall_v = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Combinational outputs are forced quiet while reset is asserted
  assign inst        = rst_n ? inst_v : NOP_INST;
  assign inst_valid  = rst_n & inst_valid_v;
  assign stall       = rst_n & stall_v;
  assign fetch_fault = rst_n & fault_v;
  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
module tb_imem_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_addr;
  logic        pc_valid;
  logic        flush;
  logic [31:0] inst;
  logic        inst_valid;
  logic        stall;
  logic        fetch_fault;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  // Expected presentations: {fault, inst}
  logic [32:0] exp_q[$];

  imem_fetch_ctrl #(.TIMEOUT_CYCLES(16), .NOP_INST(32'h0000_0000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc_addr     (pc_addr),
    .pc_valid    (pc_valid),
    .flush       (flush),
    .inst        (inst),
    .inst_valid  (inst_valid),
    .stall       (stall),
    .fetch_fault (fetch_fault),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic expect_inst(input logic fault, input logic [31:0] word);
    exp_q.push_back({fault, word});
  endtask

  // Monitor: every presented instruction must match the next expectation
  initial begin
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (inst_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_inst", inst, 32'hxxxx_xxxx);
        end else begin
          e = exp_q.pop_front();
          chk("inst", inst, e[31:0]);
          chk("fault", {31'd0, fetch_fault}, {31'd0, e[32]});
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; pc_addr = '0; pc_valid = 1'b0; flush = 1'b0;
    mem_ack = 1'b0; mem_rdata = '0;
    #3;
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_fault", {31'd0, fetch_fault}, 32'd0);
    adv(); adv();
    rst_n = 1'b1;

    // Miss at 0x0, ack in first REQ cycle, then hit
    pc_valid = 1'b1; pc_addr = 32'h0;
    smp(); chk("t1_idle_stall", {31'd0, stall}, 32'd1);
    adv();
    mem_ack = 1'b1; mem_rdata = 32'h2008_0005; expect_inst(1'b0, 32'h2008_0005);
    smp();
    chk("t1_req", {31'd0, mem_req}, 32'd1);
    chk("t1_addr", mem_addr, 32'h0);
    chk("t1_ack_stall", {31'd0, stall}, 32'd0);
    adv();
    mem_ack = 1'b0; mem_rdata = 32'hFFFF_FFFF; expect_inst(1'b0, 32'h2008_0005);
    smp();
    chk("t1_hit_req", {31'd0, mem_req}, 32'd0);
    chk("t1_hit_stall", {31'd0, stall}, 32'd0);
    adv();

    // Miss at 0x40, ack delayed 3 cycles
    pc_addr = 32'h40;
    for (int i = 0; i < 4; i++) begin
      smp();
      chk("t2_stall", {31'd0, stall}, 32'd1);
      if (i > 0) chk("t2_addr", mem_addr, 32'h40);
      adv();
    end
    mem_ack = 1'b1; mem_rdata = 32'h0800_0010; expect_inst(1'b0, 32'h0800_0010);
    smp();
    chk("t2_ack_stall", {31'd0, stall}, 32'd0);
    chk("t2_ack_addr", mem_addr, 32'h40);
    adv();
    mem_ack = 1'b0;

    // Miss at 0x8, flush in second REQ cycle, late ack discarded
    pc_addr = 32'h8;
    smp(); chk("t3_idle_stall", {31'd0, stall}, 32'd1);
    adv();
    smp(); chk("t3_req1_stall", {31'd0, stall}, 32'd1);
    adv();
    flush = 1'b1;
    smp(); chk("t3_flush_stall", {31'd0, stall}, 32'd0);
    adv();
    flush = 1'b0; pc_addr = 32'h40; expect_inst(1'b0, 32'h0800_0010);
    smp();
    chk("t3_drain_req", {31'd0, mem_req}, 32'd1);
    chk("t3_drain_hit_stall", {31'd0, stall}, 32'd0);
    adv();
    pc_addr = 32'h100; mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    smp();
    chk("t3_drain_req2", {31'd0, mem_req}, 32'd1);
    chk("t3_drain_miss_stall", {31'd0, stall}, 32'd1);
    adv();
    mem_ack = 1'b0; pc_addr = 32'h8;
    smp();
    chk("t3_after_req", {31'd0, mem_req}, 32'd0);
    chk("t3_refetch_stall", {31'd0, stall}, 32'd1);
    adv();
    mem_ack = 1'b1; mem_rdata = 32'h1111_2222; expect_inst(1'b0, 32'h1111_2222);
    smp(); chk("t3_refetch_addr", mem_addr, 32'h8);
    adv();
    mem_ack = 1'b0;

    // Misaligned PC faults without a request; buffer survives
    pc_addr = 32'h6; expect_inst(1'b1, 32'h0);
    smp();
    chk("t4_stall", {31'd0, stall}, 32'd0);
    adv();
    pc_addr = 32'h8; expect_inst(1'b0, 32'h1111_2222);
    smp();
    chk("t4_req", {31'd0, mem_req}, 32'd0);
    chk("t4_hit_stall", {31'd0, stall}, 32'd0);
    adv();

    // Timeout: no ack for 16 REQ cycles
    pc_addr = 32'hC;
    smp(); chk("t5_idle_stall", {31'd0, stall}, 32'd1);
    adv();
    for (int i = 1; i < 16; i++) begin
      smp();
      chk("t5_wait_stall", {31'd0, stall}, 32'd1);
      adv();
    end
    expect_inst(1'b1, 32'h0);
    smp();
    chk("t5_to_stall", {31'd0, stall}, 32'd0);
    chk("t5_to_req", {31'd0, mem_req}, 32'd1);
    adv();
    smp();
    chk("t5_req_fell", {31'd0, mem_req}, 32'd0);
    chk("t5_retry_stall", {31'd0, stall}, 32'd1);
    adv();
    smp();
    chk("t5_retry_req", {31'd0, mem_req}, 32'd1);
    chk("t5_retry_addr", mem_addr, 32'hC);

    // Reset mid-REQ acts without a clock edge
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_req", {31'd0, mem_req}, 32'd0);
    chk("t6_valid", {31'd0, inst_valid}, 32'd0);
    chk("t6_stall", {31'd0, stall}, 32'd0);
    adv();
    rst_n = 1'b1; pc_addr = 32'h0;
    smp(); chk("t6_miss_stall", {31'd0, stall}, 32'd1);
    adv();
    mem_ack = 1'b1; mem_rdata = 32'h2008_0005; expect_inst(1'b0, 32'h2008_0005);
    adv();
    mem_ack = 1'b0; pc_valid = 1'b0;
    adv(); adv();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
